// File: rtl/multi_blinker_if.sv
// multi_blinker_if: configuration write channel carrying mode, period and duty per channel
interface multi_blinker_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 26,
    parameter int PWM_W = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [PWM_W-1:0] cfg_duty;
    modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty, output cfg_ready);
endinterface

// File: rtl/multi_blinker.sv
// multi_blinker: independent LED channels with OFF/ON/BLINK/PULSE modes and shared PWM dimming
module multi_blinker #(
    parameter int NCH   = 4,
    parameter int CNT_W = 26,
    parameter int PWM_W = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    multi_blinker_if.slave cfg,
    output logic [NCH-1:0] led_o,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, BLINK = 2'b10, PULSE = 2'b11} mode_t;
    logic             r_ready;
    logic [PWM_W-1:0] r_pwm;
    logic             w_acc;
    assign w_acc         = cfg.cfg_valid & r_ready;
    assign cfg.cfg_ready = r_ready;
    // Handshake: refuse the cycle right after every accepted write
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) r_ready <= 1'b0;
        else         r_ready <= ~w_acc;
    // Shared brightness counter, free-running and wrapping naturally
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) r_pwm <= '0;
        else         r_pwm <= r_pwm + 1'b1;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mode_t            r_mode;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_per;
        logic [PWM_W-1:0] r_duty;
        logic             r_lvl;
        logic             r_done;
        logic             r_led;
        logic             w_wr;
        logic             w_tc;
        assign w_wr = w_acc && (cfg.cfg_ch == CH_W'(g));
        assign w_tc = r_cnt == r_per;
        // Channel state: a write overrides whatever the old configuration would do on this edge
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                r_mode <= OFF;
                r_cnt  <= '0;
                r_per  <= '0;
                r_duty <= '0;
                r_lvl  <= 1'b0;
                r_done <= 1'b0;
            end else if (w_wr) begin
                r_mode <= mode_t'(cfg.cfg_mode);
                r_cnt  <= '0;
                r_per  <= cfg.cfg_period;
                r_duty <= cfg.cfg_duty;
                r_lvl  <= cfg.cfg_mode != OFF;
                r_done <= 1'b0;
            end else begin
                r_done <= 1'b0;
                case (r_mode)
                    OFF: begin
                        r_cnt <= '0;
                        r_lvl <= 1'b0;
                    end
                    ON: begin
                        r_cnt <= '0;
                        r_lvl <= 1'b1;
                    end
                    BLINK: begin
                        r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
                        r_lvl <= r_lvl ^ w_tc;
                    end
                    PULSE: begin
                        r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
                        r_lvl  <= ~w_tc;
                        r_done <= w_tc;
                        r_mode <= w_tc ? OFF : PULSE;
                    end
                endcase
            end
        end
        // LED drive: level gated by the duty compare, one register stage behind the level
        always_ff @(posedge sys_clk or posedge sys_rst)
            if (sys_rst) r_led <= 1'b0;
            else         r_led <= r_lvl && (r_pwm <= r_duty);
        assign led_o[g] = r_led;
        assign busy[g]  = r_mode == PULSE;
        assign done[g]  = r_done;
    end
endmodule

// File: doc/multi_blinker.md
MULTI_BLINKER -- requirements
Module: multi_blinker

Interface
REQ-001 Parameter NCH, default 4: number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 26: width of the per-channel period counter.
REQ-003 Parameter PWM_W, default 4: width of the shared brightness PWM counter.
REQ-004 Port sys_clk  input  1: system clock (100 MHz); all logic on its rising edge.
REQ-005 Port sys_rst  input  1: reset, asynchronous, active-high.
REQ-006 Port cfg_valid  input  1: configuration write request.
REQ-007 Port cfg_ready  output  1: block can accept a configuration write.
REQ-008 Port cfg_ch  input  max(1,$clog2(NCH)): target channel index.
REQ-009 Port cfg_mode  input  2: 00 OFF, 01 ON, 10 BLINK, 11 PULSE.
REQ-010 Port cfg_period  input  CNT_W: terminal count P; one phase lasts P+1 cycles.
REQ-011 Port cfg_duty  input  PWM_W: brightness D.
REQ-012 Port led_o  output  NCH: LED drive per channel.
REQ-013 Port busy  output  NCH: channel is executing a PULSE.
REQ-014 Port done  output  NCH: one-cycle strobe at normal PULSE completion.

Function
REQ-015 Write accepted on a rising edge where cfg_valid=1 and cfg_ready=1.
REQ-016 cfg_ready SHALL be 0 in the cycle following an accepted write and 1 otherwise when out of reset, so at most one write is accepted every 2 cycles.
REQ-017 An accepted write with cfg_ch >= NCH SHALL be consumed, handshake included, with no state change.
REQ-018 An accepted write SHALL latch mode, P and D for cfg_ch and take effect on the next cycle.
REQ-019 The same write SHALL clear that channel's counter and set its logical level: 0 for OFF, 1 for ON, BLINK and PULSE.
REQ-020 OFF: level 0; counter held at 0.
REQ-021 ON: level 1; counter held at 0.
REQ-022 BLINK: counter increments each cycle; at count==P it SHALL reset to 0 and toggle the level.
REQ-023 BLINK with P=0 SHALL toggle the level every cycle.
REQ-024 PULSE: level 1 and busy 1 from the first cycle after the write.
REQ-025 PULSE: at count==P, level, busy and mode SHALL become 0 (OFF), done[ch] SHALL be 1 for exactly that next cycle, and level stays high for exactly P+1 cycles.
REQ-026 A write to a channel during its PULSE SHALL restart or replace the pulse with no done strobe; writing OFF aborts it with busy cleared next cycle.
REQ-027 A write landing on the same edge as a channel's terminal count SHALL win: no toggle or done from the old configuration.
REQ-028 The shared PWM counter is free-running modulo 2^PWM_W and wraps without a gap.
REQ-029 led_o[ch] = level AND (pwm_cnt <= D), registered, adding one cycle after the level.
REQ-030 D = all-ones SHALL give a constant-high led_o whenever the level is 1.
REQ-031 Counters SHALL wrap only through REQ-022/025 comparison; count never exceeds P, and unsigned compare is at full CNT_W width.
REQ-032 Channels SHALL be fully independent; a write to one never disturbs another's counter, level or phase.

Reset
REQ-033 While sys_rst=1: led_o=0, busy=0, done=0, cfg_ready=0, all modes OFF, all counters, P and D 0, pwm_cnt 0.
REQ-034 Reset asserted mid-PULSE SHALL abort it with no done strobe; cfg_ready SHALL rise on the first edge after sys_rst deasserts.

Verification
REQ-035 Reset release, no writes -> led_o=0, busy=0, done=0 indefinitely; cfg_ready=1 from the first edge.
REQ-036 Write ch0 BLINK P=4 D=15 -> led_o[0] is high 5, low 5 cycles repeating; other channels stay 0.
REQ-037 Write ch1 PULSE P=9 D=15 -> busy[1] high 10 cycles, led_o[1] high 10 cycles, done[1] one cycle, then all 0.
REQ-038 Write ch2 ON D=3, PWM_W=4 -> led_o[2] high 4 of every 16 cycles, periodic with no gap at wrap.
REQ-039 PULSE P=20 on ch3, rewrite PULSE P=5 at cycle 10 -> no done at cycle 21; done[3] exactly 6 cycles after the rewrite takes effect.
REQ-040 Back-to-back cfg_valid=1 writes -> every second cycle accepted; write with cfg_ch=NCH leaves all channels unchanged; sys_rst during PULSE -> busy and led_o 0 immediately, no done.
